// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one LATENCY-deep pipelined fp16 multiplier among NUM_REQ requesters.
// Define FP_MUL_ARB_STATS_EN to build the saturating overflow/underflow event counters.
module fp_mul_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 3,
  parameter int RSP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [18*NUM_REQ-1:0]   rsp_data,
  output logic [15:0]             mul_a,
  output logic [15:0]             mul_b,
  input  logic [15:0]             mul_result,
  input  logic                    mul_overflow,
  input  logic                    mul_underflow,
  output logic                    idle,
  output logic [15:0]             stat_ovf_cnt,
  output logic [15:0]             stat_unf_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_idle;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [LATENCY-1:0] r_tag_vld;
  logic [IDX_W-1:0]   r_tag_id [LATENCY];
  logic [CNT_W-1:0]   r_credit [NUM_REQ];
  logic [CNT_W-1:0]   r_cnt    [NUM_REQ];
  logic [PTR_W-1:0]   r_wr_ptr [NUM_REQ];
  logic [PTR_W-1:0]   r_rd_ptr [NUM_REQ];
  logic [17:0]        r_mem    [NUM_REQ][RSP_DEPTH];

  logic [NUM_REQ-1:0] w_elig, w_push, w_pop;
  logic [15:0]        w_op_a [NUM_REQ];
  logic [15:0]        w_op_b [NUM_REQ];
  logic               w_gnt_vld, w_hit, w_pipe_busy;
  logic [IDX_W-1:0]   w_gnt_idx, w_cand;
  logic               w_ret_vld;
  logic [IDX_W-1:0]   w_ret_tag;
  logic [17:0]        w_ret_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (int'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_ret_vld  = r_tag_vld[LATENCY-1];
  assign w_ret_tag  = r_tag_id[LATENCY-1];
  assign w_ret_data = {mul_underflow, mul_overflow, mul_result};
  assign idle       = r_idle;

  // Unpack operands and flag requesters that hold both a request and a credit.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_op_a[i] = req_a[16*i +: 16];
      w_op_b[i] = req_b[16*i +: 16];
      w_elig[i] = req_valid[i] && (r_credit[i] != '0);
    end
  end

  // Round-robin search from the pointer; first eligible requester wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_hit     = 1'b0;
    if ((r_state == S_RUN) && en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand    = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        w_hit     = !w_gnt_vld && w_elig[w_cand];
        w_gnt_idx = w_hit ? w_cand : w_gnt_idx;
        w_gnt_vld = w_gnt_vld | w_hit;
      end
    end else begin
      w_gnt_vld = 1'b0;
    end
  end

  // Grant handshake and multiplier operand mux.
  always_comb begin
    req_ready = '0;
    mul_a     = 16'h0000;
    mul_b     = 16'h0000;
    if (w_gnt_vld) begin
      req_ready[w_gnt_idx] = 1'b1;
      mul_a                = w_op_a[w_gnt_idx];
      mul_b                = w_op_b[w_gnt_idx];
    end else begin
      req_ready = '0;
    end
  end

  // Response FIFO heads, pop/push strobes.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    w_pop     = '0;
    w_push    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i]         = (r_cnt[i] != '0);
      rsp_data[18*i +: 18] = rsp_valid[i] ? r_mem[i][r_rd_ptr[i]] : 18'h00000;
      w_pop[i]             = rsp_valid[i] & rsp_ready[i];
      w_push[i]            = w_ret_vld && (w_ret_tag == IDX_W'(i));
    end
  end

  // Ops that will still be in flight after this cycle (the retiring stage excluded).
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < LATENCY - 1; k++) begin
      w_pipe_busy = w_pipe_busy | r_tag_vld[k];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = en ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = en ? S_RUN : (w_pipe_busy ? S_DRAIN : S_IDLE);
      S_DRAIN: w_state_nxt = en ? S_RUN : (w_pipe_busy ? S_DRAIN : S_IDLE);
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, idle flag, RR pointer and tag shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idle    <= 1'b1;
      r_rr_ptr  <= '0;
      r_tag_vld <= '0;
      for (int k = 0; k < LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idle       <= (w_state_nxt == S_IDLE);
      if (w_gnt_vld) begin
        r_rr_ptr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + IDX_W'(1);
      end
      r_tag_vld[0] <= w_gnt_vld;
      r_tag_id[0]  <= w_gnt_idx;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // Credits and FIFO pointers; credit + in-flight + occupancy stays RSP_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_credit[i] <= CNT_W'(RSP_DEPTH);
        r_cnt[i]    <= '0;
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
        if (w_pop[i])  r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_ONE;
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
          default: r_cnt[i] <= r_cnt[i];
        endcase
        case ({req_ready[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] - CNT_ONE;
          2'b01:   r_credit[i] <= r_credit[i] + CNT_ONE;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  // FIFO storage; contents are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_ret_data;
    end
  end

`ifdef FP_MUL_ARB_STATS_EN
  logic [15:0] r_ovf_cnt, r_unf_cnt;

  // Saturating flag counters over retired ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= 16'h0000;
      r_unf_cnt <= 16'h0000;
    end else begin
      if (w_ret_vld && mul_overflow && (r_ovf_cnt != 16'hFFFF))  r_ovf_cnt <= r_ovf_cnt + 16'h0001;
      if (w_ret_vld && mul_underflow && (r_unf_cnt != 16'hFFFF)) r_unf_cnt <= r_unf_cnt + 16'h0001;
    end
  end

  assign stat_ovf_cnt = r_ovf_cnt;
  assign stat_unf_cnt = r_unf_cnt;
`else
  assign stat_ovf_cnt = 16'h0000;
  assign stat_unf_cnt = 16'h0000;
`endif

endmodule
